// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared RV32I constants, opcodes and fetch FSM encoding
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_ADDI  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;

    typedef enum logic [0:0] {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch stage bus: ROM port, decode handshake, redirect
interface inst_fetch_if;
    import cpu_pkg::*;

    logic            imem_en;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_en, imem_addr, inst_valid, inst, inst_pc,
        input  imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, inst_valid, inst, inst_pc,
        output imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two FIFO with flush; head word read from storage
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // When full, a simultaneous pop frees exactly the slot being written.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32I fetch stage: PC, ROM issue, epoch-tagged response buffering
// Optional: IF_MISALIGN_EN adds misalign_err and a HALT state on misaligned redirects.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INST   = cpu_pkg::NOP_INST
) (
    input  logic clk,
    input  logic rst,
`ifdef IF_MISALIGN_EN
    output logic misalign_err,
`endif
    inst_fetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_W = OW'(FIFO_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic            epoch_q;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_addr_q;
    logic            inflight_epoch_q;

    logic            halt;
    logic            redirect_take;
    logic            misaligned;
    logic [XLEN-1:0] target;
    logic            flush;
    logic            push;
    logic            pop;
    logic            issue;
    logic            head_valid;
    logic [OW-1:0]   occ;
    logic [CW-1:0]   count;
    logic [63:0]     head_data;

    assign halt          = (state_q == FS_HALT);
    assign redirect_take = bus.redirect_valid && !halt;
    assign misaligned    = |bus.redirect_pc[1:0];
    assign target        = bus.redirect_pc & ~32'h3;
    assign flush         = bus.redirect_valid || halt;

    assign head_valid = (count != '0) && !halt;
    assign pop        = head_valid && bus.inst_ready;

    // Occupancy counts the outstanding ROM read so a full buffer can never be overrun.
    assign occ   = {1'b0, count} + OW'(inflight_q) - OW'(pop);
    assign issue = !rst && !halt && !bus.redirect_valid && (occ < DEPTH_W);

    assign push = inflight_q && (inflight_epoch_q == epoch_q) && !flush;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data ({bus.imem_rdata, inflight_addr_q}),
        .pop       (pop),
        .count     (count),
        .head_data (head_data)
    );

    assign bus.imem_en    = issue;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = head_valid;
    assign bus.inst       = head_valid ? head_data[63:32] : NOP_INST;
    assign bus.inst_pc    = head_valid ? head_data[31:0]  : '0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FS_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
`ifdef IF_MISALIGN_EN
        if (redirect_take && misaligned) state_d = FS_HALT;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_addr_q  <= '0;
            inflight_epoch_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_addr_q  <= pc_q;
                inflight_epoch_q <= epoch_q;
            end
            if (redirect_take) begin
                pc_q    <= target;
                epoch_q <= ~epoch_q;
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

`ifdef IF_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (rst)                              misalign_err <= 1'b0;
        else if (redirect_take && misaligned) misalign_err <= 1'b1;
    end
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed bench for inst_fetch with a ROM returning word index
module tb_inst_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_q = '0;
`ifdef IF_MISALIGN_EN
    logic        misalign_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    inst_fetch_if bus();

    inst_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2),
        .NOP_INST   (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef IF_MISALIGN_EN
        .misalign_err (misalign_err),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bus.imem_en) rom_q <= bus.imem_addr >> 2;
    end
    assign bus.imem_rdata = rom_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Samples the current cycle, then advances to the start of the next one.
    task automatic expect_cycle(input string tag, input logic en, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pc);
        #1;
        check({tag, ".en"}, 32'(bus.imem_en), 32'(en));
        if (en) check({tag, ".addr"}, bus.imem_addr, addr);
        check({tag, ".valid"}, 32'(bus.inst_valid), 32'(vld));
        if (vld) begin
            check({tag, ".pc"}, bus.inst_pc, pc);
            check({tag, ".inst"}, bus.inst, pc >> 2);
        end else begin
            check({tag, ".nop"}, bus.inst, 32'h0000_0013);
            check({tag, ".pc0"}, bus.inst_pc, 32'h0);
        end
        next_cycle();
    endtask

    task automatic do_reset(input logic rdy);
        rst                = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        next_cycle();
        next_cycle();
        #1;
        check("rst.en", 32'(bus.imem_en), 32'h0);
        check("rst.valid", 32'(bus.inst_valid), 32'h0);
        check("rst.inst", bus.inst, 32'h0000_0013);
        check("rst.pc", bus.inst_pc, 32'h0);
`ifdef IF_MISALIGN_EN
        check("rst.misalign", 32'(misalign_err), 32'h0);
`endif
        next_cycle();
        rst            = 1'b0;
        bus.inst_ready = rdy;
    endtask

    initial begin
        do_reset(1'b1);
        for (int k = 0; k < 12; k++)
            expect_cycle($sformatf("stream%0d", k), 1'b1, 32'(4 * k), k >= 2, 32'(4 * (k - 2)));

        do_reset(1'b0);
        expect_cycle("bp0", 1'b1, 32'h0, 1'b0, 32'h0);
        expect_cycle("bp1", 1'b1, 32'h4, 1'b0, 32'h0);
        expect_cycle("bp2", 1'b0, 32'h0, 1'b1, 32'h0);
        expect_cycle("bp3", 1'b0, 32'h0, 1'b1, 32'h0);
        expect_cycle("bp4", 1'b0, 32'h0, 1'b1, 32'h0);
        bus.inst_ready = 1'b1;
        expect_cycle("bp5", 1'b1, 32'h8,  1'b1, 32'h0);
        expect_cycle("bp6", 1'b1, 32'hC,  1'b1, 32'h4);
        expect_cycle("bp7", 1'b1, 32'h10, 1'b1, 32'h8);
        expect_cycle("bp8", 1'b1, 32'h14, 1'b1, 32'hC);

        do_reset(1'b1);
        for (int k = 0; k < 5; k++)
            expect_cycle($sformatf("pre%0d", k), 1'b1, 32'(4 * k), k >= 2, 32'(4 * (k - 2)));
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        expect_cycle("rd0", 1'b0, 32'h0, 1'b1, 32'hC);
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        expect_cycle("rd1", 1'b1, 32'h100, 1'b0, 32'h0);
        expect_cycle("rd2", 1'b1, 32'h104, 1'b0, 32'h0);
        expect_cycle("rd3", 1'b1, 32'h108, 1'b1, 32'h100);
        expect_cycle("rd4", 1'b1, 32'h10C, 1'b1, 32'h104);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0FFF_FFFC;
        expect_cycle("rp0", 1'b0, 32'h0, 1'b1, 32'h108);
        bus.redirect_valid = 1'b0;
        expect_cycle("rp1", 1'b1, 32'h0FFF_FFFC, 1'b0, 32'h0);
        expect_cycle("rp2", 1'b1, 32'h1000_0000, 1'b0, 32'h0);
        expect_cycle("rp3", 1'b1, 32'h1000_0004, 1'b1, 32'h0FFF_FFFC);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        expect_cycle("wr0", 1'b0, 32'h0, 1'b1, 32'h1000_0000);
        bus.redirect_valid = 1'b0;
        expect_cycle("wr1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        expect_cycle("wr2", 1'b1, 32'h0, 1'b0, 32'h0);
        expect_cycle("wr3", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC);
        expect_cycle("wr4", 1'b1, 32'h8, 1'b1, 32'h0);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        expect_cycle("bb0", 1'b0, 32'h0, 1'b1, 32'h4);
        bus.redirect_pc    = 32'h300;
        expect_cycle("bb1", 1'b0, 32'h0, 1'b0, 32'h0);
        bus.redirect_valid = 1'b0;
        expect_cycle("bb2", 1'b1, 32'h300, 1'b0, 32'h0);
        expect_cycle("bb3", 1'b1, 32'h304, 1'b0, 32'h0);
        expect_cycle("bb4", 1'b1, 32'h308, 1'b1, 32'h300);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        expect_cycle("ma0", 1'b0, 32'h0, 1'b1, 32'h304);
        bus.redirect_valid = 1'b0;
`ifdef IF_MISALIGN_EN
        expect_cycle("ma1", 1'b0, 32'h0, 1'b0, 32'h0);
        check("ma.err", 32'(misalign_err), 32'h1);
        expect_cycle("ma2", 1'b0, 32'h0, 1'b0, 32'h0);
        expect_cycle("ma3", 1'b0, 32'h0, 1'b0, 32'h0);
`else
        expect_cycle("ma1", 1'b1, 32'h100, 1'b0, 32'h0);
        expect_cycle("ma2", 1'b1, 32'h104, 1'b0, 32'h0);
        expect_cycle("ma3", 1'b1, 32'h108, 1'b1, 32'h100);
`endif

        do_reset(1'b1);
        expect_cycle("post0", 1'b1, 32'h0, 1'b0, 32'h0);
        expect_cycle("post1", 1'b1, 32'h4, 1'b0, 32'h0);
        expect_cycle("post2", 1'b1, 32'h8, 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
